// File: rtl/bcd_sub_serial_pkg.sv
// bcd_sub_serial_pkg: shared FSM states and BCD constants for the serial BCD subtractor
package bcd_sub_serial_pkg;
    typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;
    localparam int DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_RADIX = 4'd10;
endpackage

// File: rtl/bcd_sub_serial_sub1digit.sv
// bcd_sub1digit: one BCD digit x - y - bin -> digit d and borrow bout (ports x_i, y_i, bin_i, d_o, bout_o)
module bcd_sub1digit
    import bcd_sub_serial_pkg::*;
(
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       bin_i,
    output logic [3:0] d_o,
    output logic       bout_o
);
    logic [5:0] t;
    // t is a signed 6-bit difference; its sign bit is the borrow
    assign t      = {2'b00, x_i} - {2'b00, y_i} - {5'b0, bin_i};
    assign bout_o = t[5];
    assign d_o    = t[5] ? 4'(t + {2'b00, BCD_RADIX}) : t[3:0];
endmodule

// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial: digit-serial packed-BCD subtractor A-B, LSD first, start/done handshake
//   in : clk, rst_n (async active-low), start, a, b (packed BCD, DIGITS digits)
//   out: busy, done (1-cycle pulse), diff, borrow_out, sign, invalid
//   BCD_SUB_SIGN_EN: on a borrow, negate the result serially so diff=|A-B| and sign=1
module bcd_sub_serial
    import bcd_sub_serial_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  borrow_out,
    output logic                  sign,
    output logic                  invalid
);
    localparam int W  = DIGIT_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    state_t state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d, shifted;
    logic [CW-1:0] cnt_q, cnt_d;
    logic brw_q, brw_d, inv_q, inv_d, bo_q, bo_d, sign_q, sign_d, invo_q, invo_d;
    logic inv_scan, last, bout;
    logic [3:0] x, y, d;
    always_comb begin
        inv_scan = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (a[DIGIT_W*i +: DIGIT_W] > BCD_MAX || b[DIGIT_W*i +: DIGIT_W] > BCD_MAX) inv_scan = 1'b1;
    end
    // NEG reuses the digit slice as 0 - result, feeding the result reg back on itself
    assign x    = state_q == NEG ? 4'd0 : a_q[3:0];
    assign y    = state_q == NEG ? res_q[3:0] : b_q[3:0];
    assign last = cnt_q == CW'(DIGITS - 1);
    assign shifted = (res_q >> DIGIT_W) | (W'(d) << (W - DIGIT_W));
    bcd_sub1digit u_digit (.x_i(x), .y_i(y), .bin_i(brw_q), .d_o(d), .bout_o(bout));
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        res_d = res_q;
        cnt_d = cnt_q;
        brw_d = brw_q;
        inv_d = inv_q;
        diff_d = diff_q;
        bo_d = bo_q;
        sign_d = sign_q;
        invo_d = invo_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = start ? RUN : IDLE;
                if (start) begin
                    a_d = a;
                    b_d = b;
                    brw_d = 1'b0;
                    cnt_d = '0;
                    inv_d = inv_scan;
                end
            end
            RUN: begin
                a_d = a_q >> DIGIT_W;
                b_d = b_q >> DIGIT_W;
                res_d = shifted;
                brw_d = bout;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
`ifdef BCD_SUB_SIGN_EN
                    if (bout && !inv_q) begin
                        state_d = NEG;
                        cnt_d = '0;
                        brw_d = 1'b0;
                    end else begin
                        state_d = DONE;
                        diff_d = inv_q ? '0 : shifted;
                        bo_d = 1'b0;
                        sign_d = 1'b0;
                        invo_d = inv_q;
                    end
`else
                    state_d = DONE;
                    diff_d = inv_q ? '0 : shifted;
                    bo_d = !inv_q && bout;
                    sign_d = 1'b0;
                    invo_d = inv_q;
`endif
                end
            end
`ifdef BCD_SUB_SIGN_EN
            NEG: begin
                res_d = shifted;
                brw_d = bout;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    diff_d = shifted;
                    bo_d = 1'b1;
                    sign_d = 1'b1;
                    invo_d = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
            brw_q <= 1'b0;
            inv_q <= 1'b0;
            diff_q <= '0;
            bo_q <= 1'b0;
            sign_q <= 1'b0;
            invo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
            brw_q <= brw_d;
            inv_q <= inv_d;
            diff_q <= diff_d;
            bo_q <= bo_d;
            sign_q <= sign_d;
            invo_q <= invo_d;
        end
    end
    assign busy       = state_q == RUN || state_q == NEG;
    assign done       = state_q == DONE;
    assign diff       = diff_q;
    assign borrow_out = bo_q;
    assign sign       = sign_q;
    assign invalid    = invo_q;
endmodule

// File: tb/tb_bcd_sub_serial.sv
// tb_bcd_sub_serial: scoreboard-driven self-checking bench for bcd_sub_serial (DIGITS=4)
module tb_bcd_sub_serial;
    localparam int D = 4;
    typedef struct {
        logic [15:0] diff;
        logic        bo;
        logic        sign;
        logic        inv;
        int          lat;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic busy, done, borrow_out, sign, invalid;
    logic [15:0] diff;
    int checks = 0, errors = 0;
    exp_t sb[$];
    always #5 clk = ~clk;
    bcd_sub_serial #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
        .sign(sign), .invalid(invalid)
    );
    function automatic exp_t model(logic [15:0] x, logic [15:0] y);
        exp_t e;
        int xv = 0, yv = 0, r;
        bit bad = 0;
        e = '{diff: '0, bo: 1'b0, sign: 1'b0, inv: 1'b0, lat: D};
        for (int i = 3; i >= 0; i--) begin
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1;
            xv = xv * 10 + int'(x[4*i +: 4]);
            yv = yv * 10 + int'(y[4*i +: 4]);
        end
        if (bad) e.inv = 1'b1;
        else begin
            r = xv - yv;
            if (r < 0) begin
                e.bo = 1'b1;
`ifdef BCD_SUB_SIGN_EN
                r = -r;
                e.sign = 1'b1;
                e.lat = 2 * D;
`else
                r = r + 10000;
`endif
            end
            for (int i = 0; i < 4; i++) begin
                e.diff[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end
        return e;
    endfunction
    task automatic issue(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        sb.push_back(model(x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'h5555;
        b = 16'h7777;
    endtask
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask
    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, diff, borrow_out, sign, invalid} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {busy, done, diff, borrow_out, sign, invalid});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic test_basic();
        int lat, bcnt;
        exp_t e;
        issue(16'h4321, 16'h1234);
        wait_done(lat, bcnt);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, e.lat); end
        checks++;
        if (bcnt !== D) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", bcnt, D); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        checks++;
        if ({diff, borrow_out, sign, invalid} !== {e.diff, e.bo, e.sign, e.inv}) begin
            errors++;
            $display("FAIL basic_result got %h/%b%b%b want %h/%b%b%b", diff, borrow_out, sign, invalid, e.diff, e.bo, e.sign, e.inv);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy, diff} !== {2'b00, e.diff}) begin
            errors++;
            $display("FAIL basic_hold got done=%b busy=%b diff=%h want 0 0 %h", done, busy, diff, e.diff);
        end
    endtask
    task automatic test_patterns();
        logic [15:0] xs[5] = '{16'h0000, 16'h5000, 16'h1000, 16'h9999, 16'h0123};
        logic [15:0] ys[5] = '{16'h0001, 16'h5000, 16'h0001, 16'h0000, 16'h9876};
        int lat, bcnt;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(xs[i], ys[i]);
            wait_done(lat, bcnt);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL pattern%0d_latency got %0d want %0d", i, lat, e.lat); end
            checks++;
            if ({diff, borrow_out, sign, invalid} !== {e.diff, e.bo, e.sign, e.inv}) begin
                errors++;
                $display("FAIL pattern%0d_result got %h/%b%b%b want %h/%b%b%b", i, diff, borrow_out, sign, invalid, e.diff, e.bo, e.sign, e.inv);
            end
        end
    endtask
    task automatic test_invalid();
        int lat, bcnt;
        exp_t e;
        issue(16'h12A4, 16'h0000);
        wait_done(lat, bcnt);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL invalid_latency got %0d want %0d", lat, e.lat); end
        checks++;
        if ({diff, borrow_out, sign, invalid} !== {e.diff, e.bo, e.sign, e.inv}) begin
            errors++;
            $display("FAIL invalid_result got %h/%b%b%b want %h/%b%b%b", diff, borrow_out, sign, invalid, e.diff, e.bo, e.sign, e.inv);
        end
        issue(16'h0001, 16'h00B0);
        wait_done(lat, bcnt);
        e = sb.pop_front();
        checks++;
        if ({diff, borrow_out, invalid} !== {e.diff, e.bo, e.inv}) begin
            errors++;
            $display("FAIL invalid_b_result got %h/%b%b want %h/%b%b", diff, borrow_out, invalid, e.diff, e.bo, e.inv);
        end
        issue(16'h0050, 16'h0020);
        wait_done(lat, bcnt);
        e = sb.pop_front();
        checks++;
        if ({diff, borrow_out, invalid} !== {e.diff, e.bo, e.inv}) begin
            errors++;
            $display("FAIL invalid_clear got %h/%b%b want %h/%b%b", diff, borrow_out, invalid, e.diff, e.bo, e.inv);
        end
    endtask
    task automatic test_ignore_start();
        int lat, bcnt;
        exp_t e;
        issue(16'h8642, 16'h2468);
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 16'h0000;
        b = 16'h9999;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        lat += 2;
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat, e.lat); end
        checks++;
        if ({diff, borrow_out, sign, invalid} !== {e.diff, e.bo, e.sign, e.inv}) begin
            errors++;
            $display("FAIL ignore_result got %h/%b%b%b want %h/%b%b%b", diff, borrow_out, sign, invalid, e.diff, e.bo, e.sign, e.inv);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_phantom got busy=%b want 0", busy); end
    endtask
    task automatic test_back_to_back();
        int lat, bcnt;
        exp_t e;
        issue(16'h7000, 16'h0007);
        wait_done(lat, bcnt);
        e = sb.pop_front();
        checks++;
        if ({diff, borrow_out, sign, invalid} !== {e.diff, e.bo, e.sign, e.inv}) begin
            errors++;
            $display("FAIL b2b_first got %h/%b%b%b want %h/%b%b%b", diff, borrow_out, sign, invalid, e.diff, e.bo, e.sign, e.inv);
        end
        issue(16'h0010, 16'h0011);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
        wait_done(lat, bcnt);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, e.lat); end
        checks++;
        if ({diff, borrow_out, sign, invalid} !== {e.diff, e.bo, e.sign, e.inv}) begin
            errors++;
            $display("FAIL b2b_second got %h/%b%b%b want %h/%b%b%b", diff, borrow_out, sign, invalid, e.diff, e.bo, e.sign, e.inv);
        end
    endtask
    task automatic test_async_reset();
        int lat, bcnt;
        int seen = 0;
        exp_t e;
        issue(16'h9000, 16'h0001);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        checks++;
        if ({busy, done, diff, borrow_out, sign, invalid} !== 21'd0) begin
            errors++;
            $display("FAIL areset_outputs got %h want 0", {busy, done, diff, borrow_out, sign, invalid});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
            if (i == 2) rst_n = 1'b1;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL areset_no_done got %0d pulses want 0", seen); end
        issue(16'h0500, 16'h0321);
        wait_done(lat, bcnt);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL areset_latency got %0d want %0d", lat, e.lat); end
        checks++;
        if ({diff, borrow_out, sign, invalid} !== {e.diff, e.bo, e.sign, e.inv}) begin
            errors++;
            $display("FAIL areset_result got %h/%b%b%b want %h/%b%b%b", diff, borrow_out, sign, invalid, e.diff, e.bo, e.sign, e.inv);
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_invalid();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_sub_serial.md
Name: bcd_sub_serial

Overview:
- Digit-serial, multi-digit BCD subtractor: computes A − B on packed-BCD operands, one decimal digit per clock, LSD first.
- Inverse companion to the 1-digit BCD adder; uses the same 4-bit-per-digit packed format.
- Sits in the decimal arithmetic datapath, driven by a start/done handshake from a controller.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- a  input  4*DIGITS  minuend, packed BCD, digit i = a[4i+3:4i].
- b  input  4*DIGITS  subtrahend, same format.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result valid.
- diff  output  4*DIGITS  packed BCD result.
- borrow_out  output  1  final borrow (1 ⇒ A<B).
- sign  output  1  result sign, used only with the optional feature.
- invalid  output  1  any operand digit >9 in the finished operation.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, diff=0, borrow_out=0, sign=0, invalid=0; internal shift regs, digit counter and borrow cleared. Reset mid-operation aborts immediately with no done.
- FSM states: IDLE, RUN, (NEG with feature), DONE.
  - IDLE/DONE: start=1 at edge E0 → capture a, b; clear borrow; counter=0; scan all digits for >9 into an invalid_pending reg; go to RUN.
  - RUN: each edge processes digit[counter]: t = a_d − b_d − borrow (signed 6-bit); if t<0, d=t+10 and borrow=1, else d=t and borrow=0; d shifted into the result reg MSB end. After digit DIGITS−1 → DONE (or NEG, see feature).
  - DONE: lasts one cycle; done=1; returns to IDLE unless start=1 (back-to-back accept allowed).
- Latency: digits processed at edges E1..E_DIGITS; done=1 and diff/borrow_out/invalid updated at edge E_DIGITS (cycle following the last digit).
- busy=1 from E0 through the cycle before done; busy=0 while done=1.
- start while busy=1 is ignored with no side effects.
- Outputs diff, borrow_out, sign, invalid hold their value until the next completion.
- borrow_out=1 ⇒ diff is the tens complement, A − B + 10^DIGITS.
- Invalid digit: invalid=1 and diff=0, borrow_out=0, sign=0 at done; timing unchanged.
- Operand inputs changing after E0 have no effect.

Optional Feature:
- Macro: BCD_SUB_SIGN_EN.
- Defined: if borrow_out=1 after RUN, enter NEG for DIGITS further cycles and compute 0 − diff serially with the same digit rule. Result: diff = |A−B|, sign=1, borrow_out=1, done delayed to edge E_(2·DIGITS). If borrow_out=0, NEG is skipped and sign=0.
- Not defined: no NEG state; sign is tied 0; diff is the raw tens complement.

Decomposition:
- Shared package: state enum (IDLE, RUN, NEG, DONE), BCD_MAX=9, BCD_RADIX=10, digit width constant 4.
- One natural sub-module: bcd_sub1digit, combinational (x, y, bin → d, bout). It is reused in RUN and NEG and can be checked exhaustively on its own.

Test Plan:
- DIGITS=4, a=4321, b=1234, start at E0 → done at E4; diff=3087, borrow_out=0, invalid=0; busy high for 4 cycles.
- a=0000, b=0001 → diff=9999, borrow_out=1. With BCD_SUB_SIGN_EN: diff=0001, sign=1, done at E8.
- a=5000, b=5000 → diff=0000, borrow_out=0. Also a=1000, b=0001 → diff=0999 (borrow ripples through 3 digits).
- a=12A4 (digit 0xA) → done at E4, invalid=1, diff=0000, borrow_out=0. Next valid op clears invalid.
- Start pulse at E2 during busy, with different operands → ignored; first result unchanged. Start held during DONE → new op accepted back-to-back.
- rst_n low between E2 and E3 → all outputs 0 immediately, no done pulse. A fresh start after release gives the correct result.
